qspi_ram_responder: RTL and testbench

- Synthesizable responder for the QSPI RAM interface that the design's main block drives as initiator: chip select, clock, and the four-wire io0..io3 bus.
- Oversamples the initiator's ram_clk, ram_csn and io lines on the system clock, decodes quad read/write commands, and serves them from an external byte memory port.
- Used as an on-die or FPGA-side RAM emulator and as the bench model for initiator verification.

---
 rtl/qspi_ram_responder.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_qspi_ram_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/qspi_ram_responder.sv
// qspi_ram_responder
//   QSPI RAM responder. Oversamples the initiator's ram_csn, ram_clk and io
//   lines on the system clock, decodes quad read (0xEB) and quad write (0x38)
//   commands with a 24-bit address, and serves them from an external byte
//   memory port.
//
// Ports
//   clock      in   system clock, at least 4x ram_clk
//   reset      in   synchronous, active-high reset
//   ram_csn    in   chip select from initiator, active low
//   ram_clk    in   QSPI clock from initiator (mode 0)
//   ram_io_i   in   io3..io0 sampled from the bus
//   ram_io_o   out  io3..io0 driven during the read data phase
//   ram_io_oe  out  high while the responder drives io
//   mem_addr   out  byte address to backing memory
//   mem_wdata  out  write byte
//   mem_we     out  one-clock write strobe
//   mem_re     out  one-clock read strobe
//   mem_rdata  in   read byte, valid one clock after mem_re
//   busy       out  high whenever the responder is not idle
module qspi_ram_responder #(
  parameter int ADDR_W       = 17,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ram_csn,
  input  logic              ram_clk,
  input  logic [3:0]        ram_io_i,
  output logic [3:0]        ram_io_o,
  output logic              ram_io_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  // The shift register only keeps what is ever consumed: the command byte or
  // the low ADDR_W address bits. Upper address nibbles fall off the top.
  localparam int SH_W   = (ADDR_W > 8) ? ADDR_W : 8;
  localparam int DCNT_W = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DUMMY_LAST = DCNT_W'((DUMMY_CYCLES > 0) ? (DUMMY_CYCLES - 1) : 0);
  localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [7:0]        CMD_QREAD  = 8'hEB;
  localparam logic [7:0]        CMD_QWRITE = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_WDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  // Input synchronisers
  logic        csn_s1_q, csn_s2_q;
  logic        sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic [3:0]  io_s1_q, io_s2_q;

  // Transaction state
  state_t              state_q, state_d;
  logic [2:0]          nib_cnt_q, nib_cnt_d;
  logic [SH_W-1:0]     shift_q, shift_d;
  logic                is_read_q, is_read_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic                re_pend_q;
  logic [7:0]          out_byte_q, out_byte_d;
  logic                lo_sel_q, lo_sel_d;
  logic [3:0]          io_o_q, io_o_d;
  logic                oe_q, oe_d;
  logic                busy_q;

  logic                rise_s, fall_s;
  logic [SH_W-1:0]     shift_nib_s;
  logic [7:0]          cur_byte_s;

  assign rise_s      = sclk_s2_q & ~sclk_s3_q;
  assign fall_s      = ~sclk_s2_q & sclk_s3_q;
  assign shift_nib_s = SH_W'({shift_q, io_s2_q});
  // Forward the memory byte in the cycle it arrives so a fall that lands on
  // the same clock as the load still drives the fresh byte.
  assign cur_byte_s  = re_pend_q ? mem_rdata : out_byte_q;
  assign out_byte_d  = cur_byte_s;

  // Next-state and output decode; chip select high overrides everything.
  always_comb begin
    state_d     = state_q;
    nib_cnt_d   = nib_cnt_q;
    shift_d     = shift_q;
    is_read_d   = is_read_q;
    dcnt_d      = dcnt_q;
    mem_addr_d  = mem_we_q ? (mem_addr_q + ADDR_ONE) : mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    lo_sel_d    = lo_sel_q;
    io_o_d      = io_o_q;
    oe_d        = oe_q;

    if (csn_s2_q) begin
      state_d   = ST_IDLE;
      nib_cnt_d = 3'd0;
      dcnt_d    = '0;
      lo_sel_d  = 1'b0;
      io_o_d    = 4'h0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_CMD;
          nib_cnt_d = 3'd0;
        end

        ST_CMD: begin
          if (rise_s) begin
            shift_d = shift_nib_s;
            if (nib_cnt_q == 3'd1) begin
              nib_cnt_d = 3'd0;
              if (shift_nib_s[7:0] == CMD_QREAD) begin
                is_read_d = 1'b1;
                state_d   = ST_ADDR;
              end else if (shift_nib_s[7:0] == CMD_QWRITE) begin
                is_read_d = 1'b0;
                state_d   = ST_ADDR;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              nib_cnt_d = nib_cnt_q + 3'd1;
            end
          end else begin
            state_d = ST_CMD;
          end
        end

        ST_ADDR: begin
          if (rise_s) begin
            shift_d = shift_nib_s;
            if (nib_cnt_q == 3'd5) begin
              nib_cnt_d  = 3'd0;
              mem_addr_d = shift_nib_s[ADDR_W-1:0];
              if (is_read_q) begin
                mem_re_d = 1'b1;
                dcnt_d   = '0;
                lo_sel_d = 1'b0;
                state_d  = (DUMMY_CYCLES == 0) ? ST_RDATA : ST_DUMMY;
              end else begin
                state_d = ST_WDATA;
              end
            end else begin
              nib_cnt_d = nib_cnt_q + 3'd1;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end

        ST_DUMMY: begin
          if (rise_s) begin
            if (dcnt_q == DUMMY_LAST) begin
              state_d  = ST_RDATA;
              lo_sel_d = 1'b0;
            end else begin
              dcnt_d = dcnt_q + DCNT_ONE;
            end
          end else begin
            state_d = ST_DUMMY;
          end
        end

        ST_RDATA: begin
          if (fall_s) begin
            oe_d = 1'b1;
            if (!lo_sel_q) begin
              io_o_d   = cur_byte_s[7:4];
              lo_sel_d = 1'b1;
            end else begin
              // Low nibble out: prefetch the next byte for an open-ended burst.
              io_o_d     = cur_byte_s[3:0];
              lo_sel_d   = 1'b0;
              mem_addr_d = mem_addr_q + ADDR_ONE;
              mem_re_d   = 1'b1;
            end
          end else begin
            state_d = ST_RDATA;
          end
        end

        ST_WDATA: begin
          if (rise_s) begin
            if (!nib_cnt_q[0]) begin
              shift_d   = shift_nib_s;
              nib_cnt_d = 3'd1;
            end else begin
              // The address advances the clock after the strobe (see default).
              mem_wdata_d = {shift_q[3:0], io_s2_q};
              mem_we_d    = 1'b1;
              nib_cnt_d   = 3'd0;
            end
          end else begin
            state_d = ST_WDATA;
          end
        end

        ST_IGNORE: begin
          state_d = ST_IGNORE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Synchronisers, state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      csn_s1_q    <= 1'b1;
      csn_s2_q    <= 1'b1;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      io_s1_q     <= 4'h0;
      io_s2_q     <= 4'h0;
      state_q     <= ST_IDLE;
      nib_cnt_q   <= 3'd0;
      shift_q     <= '0;
      is_read_q   <= 1'b0;
      dcnt_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      re_pend_q   <= 1'b0;
      out_byte_q  <= 8'h00;
      lo_sel_q    <= 1'b0;
      io_o_q      <= 4'h0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      csn_s1_q    <= ram_csn;
      csn_s2_q    <= csn_s1_q;
      sclk_s1_q   <= ram_clk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      io_s1_q     <= ram_io_i;
      io_s2_q     <= io_s1_q;
      state_q     <= state_d;
      nib_cnt_q   <= nib_cnt_d;
      shift_q     <= shift_d;
      is_read_q   <= is_read_d;
      dcnt_q      <= dcnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      re_pend_q   <= mem_re_q;
      out_byte_q  <= out_byte_d;
      lo_sel_q    <= lo_sel_d;
      io_o_q      <= io_o_d;
      oe_q        <= oe_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign ram_io_o  = io_o_q;
  assign ram_io_oe = oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_qspi_ram_responder.sv
// tb_qspi_ram_responder
//   Directed bench for qspi_ram_responder: acts as the QSPI initiator with
//   ram_clk at 1/8 of the system clock, and models a synchronous byte memory
//   behind the mem_* port.
module tb_qspi_ram_responder;

  localparam int ADDR_W = 17;
  localparam int DUMMY  = 6;

  logic              clock;
  logic              reset;
  logic              ram_csn;
  logic              ram_clk;
  logic [3:0]        ram_io_i;
  logic [3:0]        ram_io_o;
  logic              ram_io_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  int we_cnt  = 0;
  int re_cnt  = 0;
  int oe_cyc  = 0;

  logic [7:0] mem_model [0:(1<<ADDR_W)-1];

  qspi_ram_responder #(.ADDR_W(ADDR_W), .DUMMY_CYCLES(DUMMY)) dut (
    .clock     (clock),
    .reset     (reset),
    .ram_csn   (ram_csn),
    .ram_clk   (ram_clk),
    .ram_io_i  (ram_io_i),
    .ram_io_o  (ram_io_o),
    .ram_io_oe (ram_io_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous byte memory: read data valid the clock after mem_re.
  always @(posedge clock) begin
    if (mem_we) begin
      mem_model[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (mem_re) begin
      mem_rdata <= mem_model[mem_addr];
      re_cnt <= re_cnt + 1;
    end
    if (ram_io_oe) begin
      oe_cyc <= oe_cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Mode 0: io changes while ram_clk is low, responder samples on the rise.
  task automatic send_nib(input logic [3:0] n);
    ram_io_i = n;
    tick(4);
    ram_clk = 1'b1;
    tick(4);
    ram_clk = 1'b0;
  endtask

  // Responder drives after the preceding fall; sample just before the rise.
  task automatic read_nib(output logic [3:0] n);
    tick(4);
    n = ram_io_o;
    ram_clk = 1'b1;
    tick(4);
    ram_clk = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    ram_csn = 1'b0;
    tick(4);
    send_nib(cmd[7:4]);
    send_nib(cmd[3:0]);
    for (int i = 5; i >= 0; i--) send_nib(addr[i*4 +: 4]);
  endtask

  task automatic end_xfer();
    ram_csn  = 1'b1;
    ram_io_i = 4'h0;
    tick(8);
  endtask

  initial begin
    logic [3:0] nib;
    int w0;
    int r0;
    int o0;

    reset    = 1'b1;
    ram_csn  = 1'b1;
    ram_clk  = 1'b0;
    ram_io_i = 4'h0;
    tick(4);

    // Reset state
    check_eq("rst_io_o",  32'(ram_io_o),  32'h0);
    check_eq("rst_oe",    32'(ram_io_oe), 32'h0);
    check_eq("rst_we",    32'(mem_we),    32'h0);
    check_eq("rst_re",    32'(mem_re),    32'h0);
    check_eq("rst_addr",  32'(mem_addr),  32'h0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'h0);
    check_eq("rst_busy",  32'(busy),      32'h0);
    reset = 1'b0;
    tick(4);

    // Write burst: 0x0123 <= A5, 0x0124 <= C3
    w0 = we_cnt;
    send_hdr(8'h38, 24'h000123);
    check_eq("wr_busy_mid", 32'(busy), 32'h1);
    send_nib(4'hA); send_nib(4'h5); send_nib(4'hC); send_nib(4'h3);
    end_xfer();
    check_eq("wr_count", 32'(we_cnt - w0), 32'd2);
    check_eq("wr_0123", 32'(mem_model[17'h00123]), 32'hA5);
    check_eq("wr_0124", 32'(mem_model[17'h00124]), 32'hC3);
    check_eq("wr_busy_end", 32'(busy), 32'h0);

    // Read burst of the same two bytes
    send_hdr(8'hEB, 24'h000123);
    for (int i = 0; i < DUMMY; i++) send_nib(4'h0);
    check_eq("rd_oe_pre", 32'(ram_io_oe), 32'h0);
    read_nib(nib); check_eq("rd_nib0", 32'(nib), 32'hA);
    check_eq("rd_oe_on", 32'(ram_io_oe), 32'h1);
    read_nib(nib); check_eq("rd_nib1", 32'(nib), 32'h5);
    read_nib(nib); check_eq("rd_nib2", 32'(nib), 32'hC);
    read_nib(nib); check_eq("rd_nib3", 32'(nib), 32'h3);
    end_xfer();
    check_eq("rd_oe_off", 32'(ram_io_oe), 32'h0);

    // Address wrap: 0x01FFFF then 0x00000
    w0 = we_cnt;
    send_hdr(8'h38, 24'h01FFFF);
    send_nib(4'h1); send_nib(4'h1); send_nib(4'h2); send_nib(4'h2);
    end_xfer();
    check_eq("wrap_count", 32'(we_cnt - w0), 32'd2);
    check_eq("wrap_1ffff", 32'(mem_model[17'h1FFFF]), 32'h11);
    check_eq("wrap_00000", 32'(mem_model[17'h00000]), 32'h22);

    // Unknown command 0x9F followed by 8 clocks
    w0 = we_cnt; r0 = re_cnt; o0 = oe_cyc;
    ram_csn = 1'b0;
    tick(4);
    send_nib(4'h9); send_nib(4'hF);
    for (int i = 0; i < 8; i++) send_nib(4'(i + 3));
    end_xfer();
    check_eq("unk_we", 32'(we_cnt - w0), 32'd0);
    check_eq("unk_re", 32'(re_cnt - r0), 32'd0);
    check_eq("unk_oe", 32'(oe_cyc - o0), 32'd0);

    // Abort after the first data nibble of a write
    w0 = we_cnt;
    send_hdr(8'h38, 24'h000123);
    send_nib(4'hA);
    end_xfer();
    check_eq("abort_we", 32'(we_cnt - w0), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'h0);
    send_hdr(8'hEB, 24'h000123);
    for (int i = 0; i < DUMMY; i++) send_nib(4'h0);
    read_nib(nib); check_eq("abort_rd0", 32'(nib), 32'hA);
    read_nib(nib); check_eq("abort_rd1", 32'(nib), 32'h5);
    end_xfer();

    // Reset in the middle of a read
    send_hdr(8'hEB, 24'h000123);
    for (int i = 0; i < DUMMY; i++) send_nib(4'h0);
    read_nib(nib);
    reset   = 1'b1;
    ram_csn = 1'b1;
    tick(1);
    check_eq("mrst_oe",   32'(ram_io_oe), 32'h0);
    check_eq("mrst_re",   32'(mem_re),    32'h0);
    check_eq("mrst_busy", 32'(busy),      32'h0);
    tick(2);
    reset = 1'b0;
    tick(4);
    send_hdr(8'hEB, 24'h000124);
    for (int i = 0; i < DUMMY; i++) send_nib(4'h0);
    read_nib(nib); check_eq("post_rd0", 32'(nib), 32'hC);
    read_nib(nib); check_eq("post_rd1", 32'(nib), 32'h3);
    end_xfer();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
